io_port_bank: RTL

IO_PORT_BANK -- requirements
Module: io_port_bank

---
 rtl/io_port_bank_pkg.sv | 16 +
 rtl/io_sync.sv | 29 ++
 rtl/io_port_bank.sv | 117 +++++++++++
 3 files changed

// File: rtl/io_port_bank_pkg.sv
// Shared core constants and default parameter values for the IO port bank.
package io_port_bank_pkg;

    localparam int EX_STATE_BITS = 2;
    localparam int INST_WIDTH    = 12;
    localparam int DATA_WIDTH    = 8;

    localparam logic [EX_STATE_BITS-1:0] EX_Q4_TRIS = 2'd3;

    localparam int IO_PORT_NUM_PORTS      = 3;
    localparam int IO_PORT_PORT_WIDTH     = 8;
    localparam int IO_PORT_SYNC_STAGES    = 2;
    localparam int IO_PORT_TRIS_BASE      = 5;
    localparam int IO_PORT_PORT_ADDR_BASE = 5;

endpackage

// File: rtl/io_sync.sv
// Multi-stage flop synchroniser for asynchronous pad inputs.
module io_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;
    logic [STAGES-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d = {stage_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/io_port_bank.sv
// Bank of bidirectional IO ports: TRIS/latch registers, synchronised pin reads
// and per-port change-on-read detection driving a level interrupt.
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int                   NUM_PORTS      = IO_PORT_NUM_PORTS,
    parameter int                   PORT_WIDTH     = IO_PORT_PORT_WIDTH,
    parameter int                   SYNC_STAGES    = IO_PORT_SYNC_STAGES,
    parameter int                   TRIS_BASE      = IO_PORT_TRIS_BASE,
    parameter int                   PORT_ADDR_BASE = IO_PORT_PORT_ADDR_BASE,
    parameter logic [NUM_PORTS-1:0] IOC_EN         = '1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [EX_STATE_BITS-1:0]        executeState,
    input  logic [INST_WIDTH-1:0]           IR,
    input  logic [DATA_WIDTH-1:0]           WRIn,
    input  logic [4:0]                      fileAddr,
    input  logic                            rdEn,
    input  logic                            wrEn,
    input  logic [DATA_WIDTH-1:0]           wrData,
    output logic [DATA_WIDTH-1:0]           rdData,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] pinIn,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOut,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] pinOe,
    output logic                            changeIrq
);

    // rdEn/wrEn are single-cycle strobes qualified by fileAddr; there is no
    // back-pressure, every strobe takes effect on the next rising edge.

    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] tris_q, tris_d;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] lat_q, lat_d;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] snap_q, snap_d;
    logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] sync_w;
    logic [NUM_PORTS-1:0]                 armed_q, armed_d;
    logic [NUM_PORTS-1:0]                 flag_q, flag_d;
    logic [NUM_PORTS-1:0]                 tris_hit, addr_hit;
    logic                                 unused_ir;

    assign unused_ir = ^IR[INST_WIDTH-1:3];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_sync
        io_sync #(
            .WIDTH (PORT_WIDTH),
            .STAGES(SYNC_STAGES)
        ) u_sync (
            .clk_i  (clk),
            .rst_n_i(rst_n),
            .d_i    (pinIn[k*PORT_WIDTH +: PORT_WIDTH]),
            .q_o    (sync_w[k])
        );
    end

    always_comb begin
        tris_hit = '0;
        addr_hit = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            tris_hit[k] = (executeState == EX_Q4_TRIS) && (IR[2:0] == 3'(TRIS_BASE + k));
            addr_hit[k] = (fileAddr == 5'(PORT_ADDR_BASE + k));
        end
    end

    // A read re-arms the port and takes precedence over a coincident flag set.
    always_comb begin
        tris_d  = tris_q;
        lat_d   = lat_q;
        snap_d  = snap_q;
        armed_d = armed_q;
        flag_d  = flag_q;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (tris_hit[k]) begin
                tris_d[k] = WRIn[PORT_WIDTH-1:0];
            end
            if (wrEn && addr_hit[k]) begin
                lat_d[k] = wrData[PORT_WIDTH-1:0];
            end
            if (rdEn && addr_hit[k]) begin
                armed_d[k] = 1'b1;
                snap_d[k]  = sync_w[k];
                flag_d[k]  = 1'b0;
            end else if (armed_q[k] && IOC_EN[k] && (sync_w[k] != snap_q[k])) begin
                flag_d[k] = 1'b1;
            end
        end
    end

    always_comb begin
        rdData = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (addr_hit[k]) begin
                rdData[PORT_WIDTH-1:0] = sync_w[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tris_q  <= '1;
            lat_q   <= '0;
            snap_q  <= '0;
            armed_q <= '0;
            flag_q  <= '0;
        end else begin
            tris_q  <= tris_d;
            lat_q   <= lat_d;
            snap_q  <= snap_d;
            armed_q <= armed_d;
            flag_q  <= flag_d;
        end
    end

    assign pinOut    = lat_q;
    assign pinOe     = ~tris_q;
    assign changeIrq = |flag_q;

endmodule
